// File: rtl/op_cmd_seq.sv
// op_cmd_seq: queued 3-cycle AND/OR memory command sequencer (read A, read B, write C)
module op_cmd_seq #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [2:0]  cmd_a_addr,
  input  logic [2:0]  cmd_b_addr,
  input  logic [2:0]  cmd_c_addr,
  output logic [2:0]  mem_addr,
  output logic        mem_wmode,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, RD_A, RD_B, WR_C} state_t;
  state_t state, state_nxt;
  logic [9:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [9:0] cmd_q;
  logic [31:0] op_a, op_b;
  logic push, pop;
  assign cmd_ready = count < CW'(FIFO_DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign busy = state != IDLE;
  // next state, fifo pop and memory port; a write is suppressed while reset is held
  always_comb begin
    state_nxt = state;
    pop = 1'b0;
    mem_addr = '0;
    mem_wmode = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        pop = count != '0;
        state_nxt = pop ? RD_A : IDLE;
      end
      RD_A: begin
        mem_addr = cmd_q[8:6];
        state_nxt = RD_B;
      end
      RD_B: begin
        mem_addr = cmd_q[5:3];
        state_nxt = WR_C;
      end
      WR_C: begin
        mem_addr = cmd_q[2:0];
        mem_wmode = rst;
        mem_wdata = cmd_q[9] ? (op_a | op_b) : (op_a & op_b);
        pop = count != '0;
        state_nxt = pop ? RD_A : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // command storage; entries need no reset since count guards them
  always_ff @(posedge clk)
    if (rst && push) fifo[wr_ptr] <= {cmd_mode, cmd_a_addr, cmd_b_addr, cmd_c_addr};
  // fsm state, fifo pointers, operand capture and completion reporting
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cmd_q <= '0;
      op_a <= '0;
      op_b <= '0;
      result <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count + CW'(push) - CW'(pop);
      done <= state == WR_C;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cmd_q <= fifo[rd_ptr];
      end
      if (state == RD_A) op_a <= mem_rdata;
      if (state == RD_B) op_b <= mem_rdata;
      if (state == WR_C) result <= mem_wdata;
    end
  end
endmodule

// File: tb/tb_op_cmd_seq.sv
// tb_op_cmd_seq: scoreboard bench with schedule-level reference model for op_cmd_seq
module tb_op_cmd_seq;
  localparam int FIFO_DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic cmd_mode = 1'b0;
  logic [2:0] cmd_a_addr = '0, cmd_b_addr = '0, cmd_c_addr = '0;
  logic [2:0] mem_addr;
  logic mem_wmode;
  logic [31:0] mem_wdata, mem_rdata, result;
  logic done, busy;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit go = 1'b0;
  logic [31:0] mem [8];
  logic [31:0] sh [8];
  logic [31:0] init_mem [8];
  logic [31:0] res_model = '0;
  typedef struct {
    int pc;
    int pp;
    int w;
    logic [2:0] c;
    logic [31:0] wd;
  } ent_t;
  ent_t q[$];
  int last_pop = -100;

  op_cmd_seq #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr),
    .cmd_c_addr(cmd_c_addr), .mem_addr(mem_addr), .mem_wmode(mem_wmode),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .result(result),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wmode) mem[mem_addr] <= mem_wdata & 32'hFFFF_FFFE;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask

  function automatic int cnt_at(input int c);
    int n = 0;
    foreach (q[i]) if (q[i].pc < c && q[i].pp >= c) n++;
    return n;
  endfunction

  function automatic bit busy_at(input int c);
    foreach (q[i]) if (q[i].pp < c && c <= q[i].pp + 3) return 1'b1;
    return 1'b0;
  endfunction

  task automatic reinit();
    for (int i = 0; i < 8; i++) begin
      mem[i] = init_mem[i];
      sh[i] = init_mem[i];
    end
  endtask

  // one command per call; pop happens no earlier than the cycle after the push
  // and no earlier than three cycles after the previous pop
  task automatic drive(input logic v, input logic m, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    ent_t e;
    logic [31:0] wd;
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = v;
    cmd_mode = m;
    cmd_a_addr = a;
    cmd_b_addr = b;
    cmd_c_addr = c;
    if (v && cnt_at(cyc) < FIFO_DEPTH) begin
      wd = m ? (sh[a] | sh[b]) : (sh[a] & sh[b]);
      sh[c] = wd & 32'hFFFF_FFFE;
      e.pc = cyc;
      e.pp = (cyc + 1 > last_pop + 3) ? cyc + 1 : last_pop + 3;
      e.w = e.pp + 3;
      e.c = c;
      e.wd = wd;
      last_pop = e.pp;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b1;
    cmd_a_addr = 3'($urandom_range(0, 7));
    @(posedge clk);
    #1;
    q.delete();
    last_pop = -100;
    res_model = '0;
    reinit();
  endtask

  always begin
    @(negedge clk);
    #1;
    if (go) begin
      bit ew, ed;
      ent_t we;
      while (q.size() > 0 && q[0].w + 1 < cyc) void'(q.pop_front());
      ew = 1'b0;
      ed = 1'b0;
      we = '{0, 0, 0, 3'd0, 32'd0};
      foreach (q[i]) begin
        if (q[i].w == cyc) begin
          ew = rst;
          we = q[i];
        end
        if (q[i].w + 1 == cyc) begin
          ed = 1'b1;
          res_model = q[i].wd;
        end
      end
      chk("cmd_ready", 32'(cmd_ready), 32'(cnt_at(cyc) < FIFO_DEPTH));
      chk("busy", 32'(busy), 32'(busy_at(cyc)));
      chk("mem_wmode", 32'(mem_wmode), 32'(ew));
      if (ew) begin
        chk("wr_addr", 32'(mem_addr), 32'(we.c));
        chk("wr_data", mem_wdata, we.wd);
      end
      if (!busy_at(cyc)) chk("idle_port", {29'd0, mem_addr} | mem_wdata, 32'd0);
      chk("done", 32'(done), 32'(ed));
      chk("result", result, res_model);
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) init_mem[i] = $urandom;
    init_mem[2] = 32'hF0F0_F0F1;
    init_mem[5] = 32'h0FF0_0FF0;
    reinit();
    repeat (2) @(posedge clk);
    #1;
    go = 1'b1;
    idle(1);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    drive(1'b1, 1'b0, 3'd2, 3'd5, 3'd7);
    idle(6);
    chk("and_mem7", mem[7], 32'h00F0_00F0);
    chk("and_result", result, 32'h00F0_00F0);
    drive(1'b1, 1'b1, 3'd2, 3'd5, 3'd7);
    idle(6);
    chk("or_mem7", mem[7], 32'hFFF0_FFF0);
    chk("or_result", result, 32'hFFF0_FFF1);
    drive(1'b1, 1'b1, 3'd2, 3'd5, 3'd3);
    drive(1'b1, 1'b0, 3'd3, 3'd3, 3'd6);
    idle(9);
    chk("alias_result", result, 32'hFFF0_FFF0);
    chk("alias_mem6", mem[6], 32'hFFF0_FFF0);
    for (int i = 0; i < 12; i++)
      drive(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    idle(40);
    do_reset();
    drive(1'b1, 1'b0, 3'd1, 3'd2, 3'd3);
    drive(1'b1, 1'b1, 3'd4, 3'd5, 3'd6);
    drive(1'b1, 1'b0, 3'd7, 3'd0, 3'd1);
    do_reset();
    idle(1);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ready", 32'(cmd_ready), 32'd1);
    chk("rstmid_done", 32'(done), 32'd0);
    idle(8);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else drive(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    begin
      int t = 0;
      while (q.size() > 0 && t < 80) begin
        idle(1);
        t++;
      end
      chk("drain_timeout", 32'(q.size()), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
